// File: rtl/pio_mailbox_responder.sv
// ---------------------------------------------------------------------------
// pio_mailbox_responder
//
// Fabric-side responder for the HPS PIO mailbox (clk_50 domain).
// The host writes a command {request toggle, opcode[1:0]} and a 3-bit
// argument.  Each new toggle is decoded once.  A START runs a one-shot
// handshake with the job engine.  The result comes back on the response PIO,
// marked by inverting ack_toggle.
//
// Opcodes: 0 ECHO, 1 COUNT, 2 START, 3 CLEAR.
//
// Parameters:
//   SYNC_STAGES     synchroniser depth on cmd_in/arg_in (2..4)
//   TIMEOUT_CYCLES  WAIT_DONE cycle limit (only with PIO_MBOX_TIMEOUT_EN)
//
// Optional feature macro: PIO_MBOX_TIMEOUT_EN
//   When defined, a job that never completes is abandoned after
//   TIMEOUT_CYCLES cycles in WAIT_DONE.  It is acked with error=1 and
//   data=17'h1FFFF.  When undefined, WAIT_DONE waits for job_done forever.
//
// Ports:
//   clk_50_clk        in   system clock, 50 MHz
//   reset_50_reset_n  in   synchronous active-low reset
//   cmd_in[2:0]       in   bit2 request toggle, bits1:0 opcode
//   arg_in[2:0]       in   command argument
//   rsp_out[19:0]     out  {ack_toggle, busy, error, data[16:0]}
//   job_start         out  single-cycle start pulse to the job engine
//   job_arg[2:0]      out  job argument, held from job_start to job_done
//   job_done          in   single-cycle completion pulse
//   job_result[15:0]  in   job result, valid with job_done
// ---------------------------------------------------------------------------
module pio_mailbox_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_50_clk,
  input  logic        reset_50_reset_n,
  input  logic [2:0]  cmd_in,
  input  logic [2:0]  arg_in,
  output logic [19:0] rsp_out,
  output logic        job_start,
  output logic [2:0]  job_arg,
  input  logic        job_done,
  input  logic [15:0] job_result
);

  localparam logic [1:0] OP_ECHO  = 2'd0;
  localparam logic [1:0] OP_COUNT = 2'd1;
  localparam logic [1:0] OP_START = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_DONE, ACK} state_t;

  // Synchroniser chains.  Index 0 is the first flop; the last index feeds
  // all of the decode logic.
  logic [SYNC_STAGES-1:0][2:0] cmd_sync;
  logic [SYNC_STAGES-1:0][2:0] arg_sync;
  logic [2:0]                  cmd_s;
  logic [2:0]                  arg_s;

  state_t      state_q,     state_d;
  logic        req_seen_q,  req_seen_d;
  logic [1:0]  opcode_q,    opcode_d;
  logic [2:0]  arg_q,       arg_d;
  logic [16:0] data_q,      data_d;
  logic        err_q,       err_d;
  logic [16:0] job_count_q, job_count_d;
  logic [19:0] rsp_d;
  logic [2:0]  job_arg_d;
  logic        new_req;

`ifdef PIO_MBOX_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  assign cmd_s   = cmd_sync[SYNC_STAGES-1];
  assign arg_s   = arg_sync[SYNC_STAGES-1];
  assign new_req = (cmd_s[2] != req_seen_q);

  // Shift the raw PIO inputs through the synchroniser chains.
  always_ff @(posedge clk_50_clk) begin
    if (!reset_50_reset_n) begin
      cmd_sync <= '0;
      arg_sync <= '0;
    end else begin
      cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], cmd_in};
      arg_sync <= {arg_sync[SYNC_STAGES-2:0], arg_in};
    end
  end

  // State and response registers.  Reset abandons any job in flight.
  always_ff @(posedge clk_50_clk) begin
    if (!reset_50_reset_n) begin
      state_q     <= IDLE;
      req_seen_q  <= 1'b0;
      opcode_q    <= 2'd0;
      arg_q       <= 3'd0;
      data_q      <= 17'd0;
      err_q       <= 1'b0;
      job_count_q <= 17'd0;
      rsp_out     <= 20'd0;
      job_arg     <= 3'd0;
`ifdef PIO_MBOX_TIMEOUT_EN
      timer_q     <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      req_seen_q  <= req_seen_d;
      opcode_q    <= opcode_d;
      arg_q       <= arg_d;
      data_q      <= data_d;
      err_q       <= err_d;
      job_count_q <= job_count_d;
      rsp_out     <= rsp_d;
      job_arg     <= job_arg_d;
`ifdef PIO_MBOX_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  // Next-state and output decode.
  // While busy, the synced toggle can only differ from req_seen if the host
  // toggled again.  That difference is the overrun condition, and it makes
  // error sticky.  The request stays pending because req_seen is not updated.
  always_comb begin
    state_d     = state_q;
    req_seen_d  = req_seen_q;
    opcode_d    = opcode_q;
    arg_d       = arg_q;
    data_d      = data_q;
    err_d       = err_q;
    job_count_d = job_count_q;
    rsp_d       = rsp_out;
    job_arg_d   = job_arg;
    job_start   = 1'b0;
`ifdef PIO_MBOX_TIMEOUT_EN
    timer_d     = timer_q;
`endif

    if (state_q != IDLE && new_req) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (new_req) begin
          opcode_d   = cmd_s[1:0];
          arg_d      = arg_s;
          req_seen_d = cmd_s[2];
          rsp_d[18]  = 1'b1;
          // Load job_arg here so it is already valid during the job_start cycle.
          if (cmd_s[1:0] == OP_START) begin
            job_arg_d = arg_s;
          end
          state_d = EXEC;
        end
      end

      EXEC: begin
        case (opcode_q)
          OP_ECHO: begin
            data_d  = {14'd0, arg_q};
            state_d = ACK;
          end
          OP_COUNT: begin
            data_d  = job_count_q;
            state_d = ACK;
          end
          OP_START: begin
            job_start = 1'b1;
`ifdef PIO_MBOX_TIMEOUT_EN
            timer_d   = 32'd0;
`endif
            state_d   = WAIT_DONE;
          end
          default: begin
            job_count_d = 17'd0;
            err_d       = 1'b0;
            data_d      = 17'd0;
            state_d     = ACK;
          end
        endcase
      end

      WAIT_DONE: begin
        // job_done takes priority over a timeout in the same cycle.
        if (job_done) begin
          data_d = {1'b0, job_result};
          if (job_count_q != 17'h1FFFF) begin
            job_count_d = job_count_q + 17'd1;
          end
          state_d = ACK;
        end
`ifdef PIO_MBOX_TIMEOUT_EN
        else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          data_d  = 17'h1FFFF;
          state_d = ACK;
        end else begin
          timer_d = timer_q + 32'd1;
        end
`endif
      end

      ACK: begin
        // Publish the response in one shot so data and error are stable
        // whenever the host sees a new ack_toggle value.
        rsp_d   = {~rsp_out[19], 1'b0, err_d, data_q};
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pio_mailbox_responder.sv
// ---------------------------------------------------------------------------
// tb_pio_mailbox_responder
//
// Directed plus randomized bench for pio_mailbox_responder.
// The host side is modelled as toggle/ack bookkeeping.  Expected responses
// are derived from the opcode rules: echo the argument, report the job
// count, run a job, or clear.  The optional timeout scenarios are compiled
// only when PIO_MBOX_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_pio_mailbox_responder;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYCLES = 100;
  localparam logic [1:0] ECHO  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] START = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cmd_in;
  logic [2:0]  arg_in;
  logic [19:0] rsp_out;
  logic        job_start;
  logic [2:0]  job_arg;
  logic        job_done;
  logic [15:0] job_result;

  int total = 0;
  int bad = 0;
  int start_pulses = 0;

  // Host-side reference state.
  logic        host_tog = 1'b0;
  logic        exp_tog = 1'b0;
  logic        m_err = 1'b0;
  logic [16:0] m_count = 17'd0;

  pio_mailbox_responder #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_50_clk(clk),
    .reset_50_reset_n(rst_n),
    .cmd_in(cmd_in),
    .arg_in(arg_in),
    .rsp_out(rsp_out),
    .job_start(job_start),
    .job_arg(job_arg),
    .job_done(job_done),
    .job_result(job_result)
  );

  always #10 clk = ~clk;

  // Count job_start pulses mid-cycle.
  always @(negedge clk) begin
    if (job_start === 1'b1) start_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] arg);
    host_tog = ~host_tog;
    cmd_in   = {host_tog, op};
    arg_in   = arg;
  endtask

  // Apply one command's effect to the reference state.  Return the data the host should read back.
  task automatic model_cmd(input logic [1:0] op, input logic [2:0] arg,
                           input logic [15:0] result, output logic [16:0] data);
    case (op)
      ECHO:  data = {14'd0, arg};
      COUNT: data = m_count;
      START: begin
        data = {1'b0, result};
        if (m_count != 17'h1FFFF) m_count = m_count + 17'd1;
      end
      default: begin
        m_count = 17'd0;
        m_err   = 1'b0;
        data    = 17'd0;
      end
    endcase
  endtask

  function automatic logic [19:0] exp_rsp(input logic [16:0] d);
    return {exp_tog, 1'b0, m_err, d};
  endfunction

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    exp_tog = ~exp_tog;
    while (rsp_out[19] !== exp_tog && n < 400) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_ack_seen"}, {31'd0, rsp_out[19]}, {31'd0, exp_tog});
  endtask

  task automatic wait_job_start(input string tag);
    int n;
    n = 0;
    while (job_start !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_job_start"}, {31'd0, job_start}, 32'd1);
  endtask

  task automatic pulse_done(input logic [15:0] result);
    job_done   = 1'b1;
    job_result = result;
    tick(1);
    job_done   = 1'b0;
    job_result = 16'($urandom);
  endtask

  task automatic do_simple(input string tag, input logic [1:0] op, input logic [2:0] arg);
    logic [16:0] d;
    applyStimulus(op, arg);
    wait_ack(tag);
    model_cmd(op, arg, 16'd0, d);
    checkOutput(tag, {12'd0, rsp_out}, {12'd0, exp_rsp(d)});
  endtask

  task automatic do_job(input string tag, input logic [2:0] arg,
                        input logic [15:0] result, input int delay);
    logic [16:0] d;
    applyStimulus(START, arg);
    wait_job_start(tag);
    checkOutput({tag, "_job_arg"}, {29'd0, job_arg}, {29'd0, arg});
    tick(1);
    checkOutput({tag, "_start_single"}, {31'd0, job_start}, 32'd0);
    tick(delay);
    checkOutput({tag, "_arg_held"}, {29'd0, job_arg}, {29'd0, arg});
    pulse_done(result);
    wait_ack(tag);
    model_cmd(START, arg, result, d);
    checkOutput(tag, {12'd0, rsp_out}, {12'd0, exp_rsp(d)});
  endtask

  initial begin
    logic [16:0] d;
    logic [15:0] r;
    logic [1:0]  op;
    logic [2:0]  a;
    int          pulses_before;

    // Reset and idle.
    rst_n = 1'b0; cmd_in = 3'd0; arg_in = 3'd0; job_done = 1'b0; job_result = 16'd0;
    tick(3);
    checkOutput("reset_rsp", {12'd0, rsp_out}, 32'd0);
    checkOutput("reset_job_arg", {29'd0, job_arg}, 32'd0);
    checkOutput("reset_job_start", {31'd0, job_start}, 32'd0);
    rst_n = 1'b1;
    tick(10);
    checkOutput("idle_rsp", {12'd0, rsp_out}, 32'd0);
    checkOutput("idle_no_start", start_pulses, 0);

    // ECHO with exact latency: busy at edge S+1, ack at edge S+3.
    applyStimulus(ECHO, 3'd5);
    tick(SYNC_STAGES);
    checkOutput("echo_not_busy_yet", {12'd0, rsp_out}, 32'd0);
    tick(1);
    checkOutput("echo_busy", {12'd0, rsp_out}, 32'h40000);
    tick(1);
    checkOutput("echo_no_ack_early", {12'd0, rsp_out}, 32'h40000);
    tick(1);
    exp_tog = 1'b1;
    checkOutput("echo_latency", {12'd0, rsp_out}, 32'h80005);

    // START with a delayed completion, then COUNT.
    do_job("start_beef", 3'd3, 16'hBEEF, 19);
    checkOutput("start_pulse_count", start_pulses, 1);
    do_simple("count_one", COUNT, 3'd0);

    // job_done outside WAIT_DONE must not change the count.
    pulse_done(16'h1234);
    tick(3);
    do_simple("count_after_stray_done", COUNT, 3'd0);

    // Overrun: a second toggle during WAIT_DONE flags an error, and the request is still serviced.
    applyStimulus(START, 3'd1);
    wait_job_start("overrun");
    tick(5);
    applyStimulus(ECHO, 3'd6);
    m_err = 1'b1;
    tick(4);
    r = 16'($urandom);
    pulse_done(r);
    wait_ack("overrun_job");
    model_cmd(START, 3'd1, r, d);
    checkOutput("overrun_job", {12'd0, rsp_out}, {12'd0, exp_rsp(d)});
    wait_ack("overrun_pending");
    model_cmd(ECHO, 3'd6, 16'd0, d);
    checkOutput("overrun_pending", {12'd0, rsp_out}, {12'd0, exp_rsp(d)});
    do_simple("clear", CLEAR, 3'd0);
    do_simple("count_after_clear", COUNT, 3'd0);

    // Double toggle while busy: flagged but lost.
    applyStimulus(START, 3'd2);
    wait_job_start("double");
    tick(3);
    applyStimulus(ECHO, 3'd1);
    tick(3);
    applyStimulus(ECHO, 3'd1);
    m_err = 1'b1;
    tick(4);
    r = 16'($urandom);
    pulse_done(r);
    wait_ack("double_job");
    model_cmd(START, 3'd2, r, d);
    checkOutput("double_job", {12'd0, rsp_out}, {12'd0, exp_rsp(d)});
    tick(12);
    checkOutput("double_toggle_lost", {12'd0, rsp_out}, {12'd0, exp_rsp(d)});
    do_simple("clear2", CLEAR, 3'd0);

    // Randomized command mix.
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 3'($urandom);
      if (op == START) do_job("rand_job", a, 16'($urandom), $urandom_range(1, 10));
      else do_simple("rand_cmd", op, a);
    end

`ifdef PIO_MBOX_TIMEOUT_EN
    do_simple("to_pre_clear", CLEAR, 3'd0);
    applyStimulus(START, 3'd7);
    wait_job_start("timeout");
    wait_ack("timeout");
    m_err = 1'b1;
    checkOutput("timeout_rsp", {12'd0, rsp_out}, {12'd0, exp_rsp(17'h1FFFF)});
    do_simple("timeout_count", COUNT, 3'd0);
    do_simple("timeout_clear", CLEAR, 3'd0);
    applyStimulus(START, 3'd7);
    wait_job_start("to_race");
    tick(TIMEOUT_CYCLES);
    r = 16'($urandom);
    pulse_done(r);
    wait_ack("to_race");
    model_cmd(START, 3'd7, r, d);
    checkOutput("timeout_race_done_wins", {12'd0, rsp_out}, {12'd0, exp_rsp(d)});
`endif

    // Reset in WAIT_DONE: job abandoned, no reissue, late done ignored.
    applyStimulus(START, 3'd4);
    wait_job_start("reset_mid");
    tick(3);
    pulses_before = start_pulses;
    rst_n = 1'b0; cmd_in = 3'd0; arg_in = 3'd0; host_tog = 1'b0;
    tick(2);
    checkOutput("midreset_rsp", {12'd0, rsp_out}, 32'd0);
    checkOutput("midreset_job_arg", {29'd0, job_arg}, 32'd0);
    rst_n = 1'b1;
    exp_tog = 1'b0; m_err = 1'b0; m_count = 17'd0;
    tick(3);
    pulse_done(16'hDEAD);
    tick(5);
    checkOutput("no_start_reissue", start_pulses, pulses_before);
    do_simple("echo_after_reset", ECHO, 3'd2);
    checkOutput("echo_after_reset_value", {12'd0, rsp_out}, 32'h80002);
    do_simple("count_after_reset", COUNT, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_mailbox_responder.md
Name:
pio_mailbox_responder

Overview:
- Fabric-side responder for the HPS PIO mailbox.
- HPS software issues commands over the 3-bit command PIO and 3-bit argument PIO.
- This block decodes each command, optionally runs a one-shot job handshake with the CNN datapath, and returns status and data on the 20-bit response PIO using a toggle-ack handshake.
- Sits in the top level between the soc_system PIO exports and the fabric job logic, in the clk_50 domain.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on cmd_in/arg_in (legal range 2..4).
- TIMEOUT_CYCLES, 50000, WAIT_DONE cycle limit; used only when the optional feature is compiled in.

Ports:
- clk_50_clk  input  1  system clock, 50 MHz.
- reset_50_reset_n  input  1  reset, synchronous, active-low.
- cmd_in  input  3  from the command PIO. Bit2 = request toggle; bits1:0 = opcode.
- arg_in  input  3  from the argument PIO; command argument.
- rsp_out  output  20  to the response PIO. Field layout: {ack_toggle[19], busy[18], error[17], data[16:0]}.
- job_start  output  1  single-cycle start pulse to the job engine.
- job_arg  output  3  argument held stable from job_start until job_done.
- job_done  input  1  single-cycle completion pulse from the job engine.
- job_result  input  16  result, valid when job_done=1.

Behaviour:
- Reset, when reset_50_reset_n=0 at a clk_50_clk edge:
  - rsp_out=0, job_start=0, job_arg=0.
  - req_seen=0, job_count=0, all synchroniser flops 0, state=IDLE.
  - Reset mid-job abandons the job; no job_start is reissued.
- Synchronisation:
  - cmd_in and arg_in pass through SYNC_STAGES flops. All decode uses the synced values.
  - A new request exists when synced cmd bit2 != req_seen.
- States:
  - IDLE
    - On a new request: latch opcode and arg, set req_seen to the synced bit2, set busy=1, go to EXEC.
    - Otherwise hold.
  - EXEC, one cycle, by opcode:
    - 0 ECHO: data={14'b0,arg}; go to ACK.
    - 1 COUNT: data=job_count; go to ACK.
    - 2 START: job_start=1 for this cycle only; job_arg=arg; go to WAIT_DONE.
    - 3 CLEAR: job_count=0, error=0, data=0; go to ACK.
  - WAIT_DONE
    - On job_done=1: data={1'b0,job_result}, job_count+1 saturating at 17'h1FFFF, go to ACK.
  - ACK, one cycle: ack_toggle inverts, busy=0, latched data and error are driven onto rsp_out; go to IDLE.
- Latency: the ECHO/COUNT/CLEAR ack toggle is visible exactly SYNC_STAGES+3 edges after cmd_in changes.
- rsp_out changes only in the ACK cycle, except the busy bit, which sets on leaving IDLE. Data and error are therefore stable whenever ack_toggle != the host's last-seen value.
- Overrun: if synced bit2 changes while state != IDLE, error is set (sticky until CLEAR). The pending request is serviced on return to IDLE only if synced bit2 still differs from req_seen. A double toggle is lost and only flagged.
- job_done outside WAIT_DONE is ignored and does not change job_count.
- Opcode and arg changes while busy have no effect on the command in flight.

Optional Feature:
- Macro PIO_MBOX_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entering WAIT_DONE and increments each WAIT_DONE cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no job_done: error=1, data=17'h1FFFF, job_count unchanged, go to ACK.
  - job_done arriving in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; WAIT_DONE waits indefinitely for job_done.

Test Plan:
- Release reset, idle 10 cycles -> rsp_out=20'h00000, job_start never asserted.
- cmd_in=3'b100, arg_in=3'b101 (ECHO) -> busy at edge SYNC_STAGES+1; at edge SYNC_STAGES+3 rsp_out={1,0,0,17'h00005}.
- START, arg=3 -> one-cycle job_start, job_arg=3. job_done with job_result=16'hBEEF after 20 cycles -> rsp_out data=17'h0BEEF, ack toggled. A following COUNT returns data=1.
- START, then toggle bit2 again after 5 cycles while in WAIT_DONE -> error=1 in the ack. The second request is serviced after the first ack. CLEAR -> error=0, data=0, job_count=0.
- With PIO_MBOX_TIMEOUT_EN, TIMEOUT_CYCLES=100, START with no job_done -> ack after 100 WAIT_DONE cycles, error=1, data=17'h1FFFF, COUNT returns 0. With job_done on the same cycle as the timeout -> normal completion, error=0.
- Assert reset in WAIT_DONE, release, then ECHO arg=2 -> rsp_out={1,0,0,17'h2}; late job_done is ignored.
